config_chain_loader: RTL and testbench

//  Bitstream loader for the serial tile configuration chain (IO tiles, logic tiles).

---
 rtl/config_chain_loader_if.sv | 20 ++
 rtl/config_chain_loader.sv | 170 +++++++++++++++++
 tb/tb_config_chain_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_chain_loader_if.sv
// Host word channel into the configuration chain loader (valid/ready).
interface config_chain_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/config_chain_loader.sv
// Serial configuration chain loader: clears the tile chain, shifts exactly
// CHAIN_LENGTH bits taken LSB first from host words, then releases the fabric.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, fabric held off
// S_CLEAR | config_nreset low for CLEAR_CYCLES cycles
// S_LOAD  | word_ready high, waiting for a host word
// S_SHIFT | one chain bit per cycle from the captured word
// S_DONE  | chain loaded, fabric released until start or abort
module config_chain_loader #(
  parameter int CHAIN_LENGTH = 216,
  parameter int WORD_WIDTH   = 8,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  config_chain_loader_if.slave  host,
  output logic                  config_in,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  busy,
  output logic                  done,
  output logic                  fabric_nreset,
  output logic                  fabric_enable
);

  localparam int TW = $clog2(CHAIN_LENGTH + 1);
  localparam int IW = $clog2(WORD_WIDTH + 1);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  localparam logic [TW-1:0] CHAIN_LEN_T = TW'(CHAIN_LENGTH);
  localparam logic [IW-1:0] WORD_LEN_T  = IW'(WORD_WIDTH);
  localparam logic [CW-1:0] CLR_LOAD    = CW'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic [TW-1:0]         bit_total_q, bit_total_d;
  logic [CW-1:0]         clr_cnt_q, clr_cnt_d;

  logic [IW-1:0]         bit_idx_inc;
  logic [TW-1:0]         bit_total_inc;

  // Registered outputs, so every port is driven straight from a flop.
  logic word_ready_q,    word_ready_d;
  logic config_in_q,     config_in_d;
  logic config_enable_q, config_enable_d;
  logic config_nreset_q, config_nreset_d;
  logic busy_q,          busy_d;
  logic done_q,          done_d;
  logic fabric_nreset_q, fabric_nreset_d;
  logic fabric_enable_q, fabric_enable_d;

  assign bit_idx_inc   = bit_idx_q + 1'b1;
  assign bit_total_inc = bit_total_q + 1'b1;

  // State, datapath and output registers; reset leaves the chain in clear.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q         <= S_IDLE;
      shift_q         <= '0;
      bit_idx_q       <= '0;
      bit_total_q     <= '0;
      clr_cnt_q       <= '0;
      word_ready_q    <= 1'b0;
      config_in_q     <= 1'b0;
      config_enable_q <= 1'b0;
      config_nreset_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      fabric_nreset_q <= 1'b0;
      fabric_enable_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      bit_idx_q       <= bit_idx_d;
      bit_total_q     <= bit_total_d;
      clr_cnt_q       <= clr_cnt_d;
      word_ready_q    <= word_ready_d;
      config_in_q     <= config_in_d;
      config_enable_q <= config_enable_d;
      config_nreset_q <= config_nreset_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      fabric_nreset_q <= fabric_nreset_d;
      fabric_enable_q <= fabric_enable_d;
    end
  end

  // Next-state and datapath update; abort overrides start and the word handshake.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    bit_total_d = bit_total_q;
    clr_cnt_d   = clr_cnt_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d     = S_CLEAR;
            clr_cnt_d   = CLR_LOAD;
            bit_total_d = '0;
          end
        end
        S_CLEAR: begin
          if (clr_cnt_q == '0) begin
            state_d = S_LOAD;
          end else begin
            clr_cnt_d = clr_cnt_q - 1'b1;
          end
        end
        S_LOAD: begin
          if (host.word_valid) begin
            shift_d   = host.word_data;
            bit_idx_d = '0;
            state_d   = S_SHIFT;
          end
        end
        S_SHIFT: begin
          shift_d     = shift_q >> 1;
          bit_idx_d   = bit_idx_inc;
          bit_total_d = bit_total_inc;
          // Chain full wins over word exhausted: leftover word bits are dropped.
          if (bit_total_inc == CHAIN_LEN_T) begin
            state_d = S_DONE;
          end else if (bit_idx_inc == WORD_LEN_T) begin
            state_d = S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the state being entered, registered alongside it.
  always_comb begin
    word_ready_d    = (state_d == S_LOAD);
    config_enable_d = (state_d == S_SHIFT);
    config_in_d     = (state_d == S_SHIFT) ? shift_d[0] : 1'b0;
    config_nreset_d = (state_d != S_CLEAR);
    busy_d          = (state_d == S_CLEAR) || (state_d == S_LOAD) || (state_d == S_SHIFT);
    done_d          = (state_d == S_DONE);
    fabric_nreset_d = (state_d == S_DONE);
    fabric_enable_d = (state_d == S_DONE);
  end

  assign host.word_ready = word_ready_q;
  assign config_in       = config_in_q;
  assign config_enable   = config_enable_q;
  assign config_nreset   = config_nreset_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign fabric_nreset   = fabric_nreset_q;
  assign fabric_enable   = fabric_enable_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a 24-bit and a 20-bit chain instance, each
// with a chain model and a bit scoreboard fed by the host word handshake.
module tb_config_chain_loader;

  logic       clock;
  logic       nreset;
  logic [1:0] start, abort;
  logic [1:0] cfg_in, cfg_en, cfg_nrst, busy, done, fab_nrst, fab_en;

  config_chain_loader_if #(.WORD_WIDTH(8)) h0 ();
  config_chain_loader_if #(.WORD_WIDTH(8)) h1 ();

  config_chain_loader #(.CHAIN_LENGTH(24), .WORD_WIDTH(8), .CLEAR_CYCLES(2)) dut0 (
    .clock(clock), .nreset(nreset), .start(start[0]), .abort(abort[0]), .host(h0),
    .config_in(cfg_in[0]), .config_enable(cfg_en[0]), .config_nreset(cfg_nrst[0]),
    .busy(busy[0]), .done(done[0]), .fabric_nreset(fab_nrst[0]), .fabric_enable(fab_en[0]));

  config_chain_loader #(.CHAIN_LENGTH(20), .WORD_WIDTH(8), .CLEAR_CYCLES(2)) dut1 (
    .clock(clock), .nreset(nreset), .start(start[1]), .abort(abort[1]), .host(h1),
    .config_in(cfg_in[1]), .config_enable(cfg_en[1]), .config_nreset(cfg_nrst[1]),
    .busy(busy[1]), .done(done[1]), .fabric_nreset(fab_nrst[1]), .fabric_enable(fab_en[1]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  logic [23:0] chain [2];
  int          en_cnt [2];
  int          nrst_cnt [2];
  logic        q0 [$];
  logic        q1 [$];

  typedef struct {
    int          sel;
    int          gap;
    logic [7:0]  w0, w1, w2;
    int          exp_en;
    int          exp_left;
    logic [23:0] exp_chain;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Chain image after loading a three-word stream into a len-bit chain.
  function automatic logic [23:0] model_chain(logic [7:0] w0, logic [7:0] w1,
                                              logic [7:0] w2, int len);
    logic [23:0] s;
    logic [23:0] r;
    s = {w2, w1, w0};
    r = '0;
    for (int k = 0; k < len; k++) r[len-1-k] = s[k];
    return r;
  endfunction

  function automatic logic [7:0] outs(int sel);
    logic r;
    r = (sel == 0) ? h0.word_ready : h1.word_ready;
    return {r, cfg_in[sel], cfg_en[sel], cfg_nrst[sel], busy[sel], done[sel],
            fab_nrst[sel], fab_en[sel]};
  endfunction

  function automatic logic ready_of(int sel);
    return (sel == 0) ? h0.word_ready : h1.word_ready;
  endfunction

  function automatic int qsize(int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  task automatic pop_check(int sel);
    logic b;
    if (qsize(sel) == 0) begin
      check($sformatf("scoreboard_empty dut%0d", sel), 32'd1, 32'd0);
    end else begin
      if (sel == 0) b = q0.pop_front();
      else          b = q1.pop_front();
      check($sformatf("config_in_bit dut%0d", sel), {31'd0, cfg_in[sel]}, {31'd0, b});
    end
  endtask

  // Chain model and output scoreboard, sampled mid-cycle.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!cfg_nrst[i]) begin
        chain[i] = '0;
        nrst_cnt[i]++;
      end else if (cfg_en[i]) begin
        chain[i] = {chain[i][22:0], cfg_in[i]};
        en_cnt[i]++;
        pop_check(i);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic set_word(int sel, logic v, logic [7:0] d);
    if (sel == 0) begin h0.word_valid = v; h0.word_data = d; end
    else          begin h1.word_valid = v; h1.word_data = d; end
  endtask

  task automatic begin_run(int sel);
    if (sel == 0) q0.delete();
    else          q1.delete();
    en_cnt[sel]   = 0;
    nrst_cnt[sel] = 0;
  endtask

  task automatic pulse_start(int sel);
    start[sel] = 1'b1;
    tick();
    start[sel] = 1'b0;
  endtask

  // Offer one word; expected bits enter the scoreboard on the accepting edge.
  task automatic send_one(int sel, logic [7:0] w);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    set_word(sel, 1'b1, w);
    while (!ok && n < 100) begin
      if (ready_of(sel)) begin
        for (int b = 0; b < 8; b++) begin
          if (sel == 0) q0.push_back(w[b]);
          else          q1.push_back(w[b]);
        end
        ok = 1;
      end
      tick();
      n++;
    end
    set_word(sel, 1'b0, 8'h00);
    if (!ok) check($sformatf("handshake_timeout dut%0d", sel), 32'd0, 32'd1);
  endtask

  task automatic wait_done(int sel);
    int n;
    n = 0;
    while (!done[sel] && n < 200) begin
      tick();
      n++;
    end
    check($sformatf("done_reached dut%0d", sel), {31'd0, done[sel]}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0]  w [3];
    logic [23:0] mask;
    int          e;
    int          nr;
    w[0] = v.w0; w[1] = v.w1; w[2] = v.w2;
    mask = (v.sel == 0) ? 24'hFF_FFFF : 24'h0F_FFFF;
    begin_run(v.sel);
    pulse_start(v.sel);
    check($sformatf("v%0d clear_entered", idx), {30'd0, cfg_nrst[v.sel], busy[v.sel]}, 32'b01);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) repeat (v.gap) tick();
      send_one(v.sel, w[k]);
    end
    wait_done(v.sel);
    check($sformatf("v%0d clear_cycles", idx), nrst_cnt[v.sel], 32'd2);
    check($sformatf("v%0d enable_cycles", idx), en_cnt[v.sel], v.exp_en);
    check($sformatf("v%0d chain", idx), {8'd0, chain[v.sel] & mask}, {8'd0, v.exp_chain});
    check($sformatf("v%0d done_outs", idx), {24'd0, outs(v.sel)}, 32'b0001_0111);
    check($sformatf("v%0d dropped_bits", idx), qsize(v.sel), v.exp_left);
    e = en_cnt[v.sel];
    nr = 0;
    set_word(v.sel, 1'b1, 8'h55);
    repeat (3) begin
      tick();
      if (ready_of(v.sel)) nr++;
    end
    set_word(v.sel, 1'b0, 8'h00);
    check($sformatf("v%0d done_no_ready", idx), nr, 32'd0);
    check($sformatf("v%0d done_no_shift", idx), en_cnt[v.sel], e);
  endtask

  initial begin
    int e;
    int n;
    nreset = 1'b0;
    start  = '0;
    abort  = '0;
    set_word(0, 1'b0, 8'h00);
    set_word(1, 1'b0, 8'h00);
    en_cnt[0] = 0; en_cnt[1] = 0; nrst_cnt[0] = 0; nrst_cnt[1] = 0;

    vecs[0] = '{0, 0,  8'hA5, 8'h3C, 8'hFF, 24, 0, model_chain(8'hA5, 8'h3C, 8'hFF, 24)};
    vecs[1] = '{0, 10, 8'hA5, 8'h3C, 8'hFF, 24, 0, model_chain(8'hA5, 8'h3C, 8'hFF, 24)};
    vecs[2] = '{1, 0,  8'hA5, 8'h3C, 8'hFF, 20, 4, model_chain(8'hA5, 8'h3C, 8'hFF, 20)};
    vecs[3] = '{1, 2,  8'hC3, 8'h5A, 8'h81, 20, 4, model_chain(8'hC3, 8'h5A, 8'h81, 20)};
    vecs[4] = '{0, 3,  8'h12, 8'h34, 8'h56, 24, 0, model_chain(8'h12, 8'h34, 8'h56, 24)};

    tick();
    check("reset_outs dut0", {24'd0, outs(0)}, 32'd0);
    check("reset_outs dut1", {24'd0, outs(1)}, 32'd0);
    nreset = 1'b1;
    tick();
    check("idle_outs dut0", {24'd0, outs(0)}, 32'b0001_0000);
    check("idle_outs dut1", {24'd0, outs(1)}, 32'b0001_0000);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Abort part way through the second word, then a full reload.
    begin_run(0);
    pulse_start(0);
    send_one(0, 8'hA5);
    send_one(0, 8'h3C);
    n = 0;
    while (en_cnt[0] < 11 && n < 100) begin
      tick();
      n++;
    end
    check("abort_reach_11", {31'd0, en_cnt[0] >= 11}, 32'd1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("abort_idle_outs", {24'd0, outs(0)}, 32'b0001_0000);
    e = en_cnt[0];
    repeat (3) tick();
    check("abort_chain_holds", en_cnt[0], e);
    run_vec(vecs[0], 5);

    // start while shifting is ignored.
    begin_run(0);
    pulse_start(0);
    send_one(0, 8'hA5);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("start_in_shift_busy", {30'd0, busy[0], cfg_en[0]}, 32'b11);
    check("start_in_shift_no_clear", nrst_cnt[0], 32'd2);

    // start and abort together: abort wins.
    start[0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    abort[0] = 1'b0;
    check("start_abort_idle", {24'd0, outs(0)}, 32'b0001_0000);

    // Async reset in the middle of a shift.
    begin_run(0);
    pulse_start(0);
    send_one(0, 8'h3C);
    tick();
    check("pre_reset_shifting", {31'd0, cfg_en[0]}, 32'd1);
    nreset = 1'b0;
    #1;
    check("async_reset_outs dut0", {24'd0, outs(0)}, 32'd0);
    check("async_reset_outs dut1", {24'd0, outs(1)}, 32'd0);
    tick();
    nreset = 1'b1;
    tick();
    check("post_reset_idle", {24'd0, outs(0)}, 32'b0001_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
